// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame FSM state encoding,
// parity sense constants and the default word width.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/rx_hold_reg.sv
// Single-entry valid/ready holding register. A load into an empty register,
// or into a full one that is being drained in the same cycle, replaces the
// contents; a load into a full, stalled register is dropped and flagged.
module rx_hold_reg #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             overrun
);

   // Load / drain / overrun handling; data only changes on an accepted load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data    <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (load) begin
            if (!valid || ready) begin
               data  <= load_data;
               valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/uart_rx_frame_assembler.sv
// Tracks UART frame position from voted bit strobes, assembles the data word
// LSB first, checks parity and stop, and hands completed words to a
// single-entry holding register.
module uart_rx_frame_assembler
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic                  bit_strobe,
   input  logic                  bit_value,
   input  logic                  par_en,
   input  logic                  par_odd,
   input  logic                  rx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  parity_error,
   output logic                  framing_error,
   output logic                  start_glitch,
   output logic                  overrun,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_START  = ST_START;
   localparam logic [2:0] S_DATA   = ST_DATA;
   localparam logic [2:0] S_PARITY = ST_PARITY;
   localparam logic [2:0] S_STOP   = ST_STOP;

   logic [2:0]            state;
   logic                  cfg_par_en;
   logic                  cfg_par_odd;
   logic [DATA_WIDTH-1:0] shreg;
   logic [CNT_W-1:0]      cnt;
   logic                  run_par;
   logic                  perr;
   logic                  complete;
   logic [DATA_WIDTH+1:0] payload;
   logic [DATA_WIDTH+1:0] held;

   // The stop-bit strobe completes the frame; its inverted value is the
   // framing error, so the payload is formed combinationally in that cycle.
   assign complete = (state == S_STOP) && bit_strobe;
   assign payload  = {perr, ~bit_value, shreg};
   assign busy     = (state != S_IDLE);

   // Frame FSM with shift register, bit counter and running parity.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         cfg_par_en   <= 1'b0;
         cfg_par_odd  <= 1'b0;
         shreg        <= '0;
         cnt          <= '0;
         run_par      <= 1'b0;
         perr         <= 1'b0;
         start_glitch <= 1'b0;
      end else begin
         start_glitch <= 1'b0;
         case (state)
            S_IDLE: begin
               if (frame_start) begin
                  state       <= S_START;
                  cfg_par_en  <= par_en;
                  cfg_par_odd <= par_odd;
                  shreg       <= '0;
                  cnt         <= '0;
                  run_par     <= 1'b0;
                  perr        <= 1'b0;
               end
            end
            S_START: begin
               if (bit_strobe) begin
                  if (bit_value) begin
                     start_glitch <= 1'b1;
                     state        <= S_IDLE;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (bit_strobe) begin
                  shreg   <= {bit_value, shreg[DATA_WIDTH-1:1]};
                  run_par <= run_par ^ bit_value;
                  cnt     <= cnt + CNT_W'(1);
                  if (cnt == LAST_BIT) begin
                     state <= cfg_par_en ? S_PARITY : S_STOP;
                  end
               end
            end
            S_PARITY: begin
               if (bit_strobe) begin
                  perr  <= run_par ^ bit_value ^ (cfg_par_odd == PARITY_ODD);
                  state <= S_STOP;
               end
            end
            S_STOP: begin
               if (bit_strobe) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   rx_hold_reg #(
      .WIDTH (DATA_WIDTH + 2)
   ) u_hold (
      .clk       (clk),
      .rst       (rst),
      .load      (complete),
      .load_data (payload),
      .ready     (rx_ready),
      .data      (held),
      .valid     (rx_valid),
      .overrun   (overrun)
   );

   assign parity_error  = held[DATA_WIDTH+1];
   assign framing_error = held[DATA_WIDTH];
   assign rx_data       = held[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Directed bench for uart_rx_frame_assembler (DATA_WIDTH = 8). Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_uart_rx_frame_assembler;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_start;
   logic       bit_strobe;
   logic       bit_value;
   logic       par_en;
   logic       par_odd;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_error;
   logic       framing_error;
   logic       start_glitch;
   logic       overrun;
   logic       busy;

   int total = 0;
   int bad   = 0;

   uart_rx_frame_assembler #(.DATA_WIDTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .frame_start   (frame_start),
      .bit_strobe    (bit_strobe),
      .bit_value     (bit_value),
      .par_en        (par_en),
      .par_odd       (par_odd),
      .rx_ready      (rx_ready),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .parity_error  (parity_error),
      .framing_error (framing_error),
      .start_glitch  (start_glitch),
      .overrun       (overrun),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      @(negedge clk);
   endtask

   task automatic strobe(input logic v);
      bit_value  = v;
      bit_strobe = 1'b1;
      @(negedge clk);
      bit_strobe = 1'b0;
      bit_value  = 1'b0;
   endtask

   // Returns on the falling edge right after the stop strobe was taken.
   task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                             input logic pbit, input logic stop, input logic rdy_stop);
      par_en      = pen;
      par_odd     = podd;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      par_en      = 1'b0;
      par_odd     = 1'b0;
      check("busy_rise", busy, 1);
      strobe(1'b0);
      idle();
      for (int i = 0; i < 8; i++) begin
         strobe(d[i]);
         idle();
      end
      if (pen) begin
         strobe(pbit);
         idle();
      end
      rx_ready = rdy_stop;
      strobe(stop);
   endtask

   initial begin
      rst         = 1'b0;
      frame_start = 1'b0;
      bit_strobe  = 1'b0;
      bit_value   = 1'b0;
      par_en      = 1'b0;
      par_odd     = 1'b0;
      rx_ready    = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data",  rx_data, 0);
      check("rst_valid", rx_valid, 0);
      check("rst_perr",  parity_error, 0);
      check("rst_ferr",  framing_error, 0);
      check("rst_glitch", start_glitch, 0);
      check("rst_ovr",   overrun, 0);
      check("rst_busy",  busy, 0);
      rst = 1'b1;
      idle();

      // 8N1, data 0x9A
      send_frame(8'h9A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("n1_valid", rx_valid, 1);
      check("n1_data",  rx_data, 8'h9A);
      check("n1_perr",  parity_error, 0);
      check("n1_ferr",  framing_error, 0);
      check("n1_busy_fall", busy, 0);
      idle();
      check("n1_valid_drop", rx_valid, 0);
      check("n1_data_hold", rx_data, 8'h9A);

      // 8E1, 0x07 with correct then wrong parity bit
      send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      check("e1a_valid", rx_valid, 1);
      check("e1a_data",  rx_data, 8'h07);
      check("e1a_perr",  parity_error, 0);
      idle();
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check("e1b_valid", rx_valid, 1);
      check("e1b_perr",  parity_error, 1);
      check("e1b_ferr",  framing_error, 0);
      idle();

      // 8O1 0xFF, then no parity with a bad stop bit
      send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check("o1_valid", rx_valid, 1);
      check("o1_data",  rx_data, 8'hFF);
      check("o1_perr",  parity_error, 0);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("ferr_valid", rx_valid, 1);
      check("ferr_data",  rx_data, 8'hFF);
      check("ferr_perr",  parity_error, 0);
      check("ferr_ferr",  framing_error, 1);
      idle();

      // false start, then a normal frame
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check("gl_busy", busy, 1);
      strobe(1'b1);
      check("gl_pulse", start_glitch, 1);
      check("gl_busy_fall", busy, 0);
      check("gl_novalid", rx_valid, 0);
      idle();
      check("gl_pulse_end", start_glitch, 0);
      check("gl_novalid2", rx_valid, 0);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("gl_next_valid", rx_valid, 1);
      check("gl_next_data",  rx_data, 8'h5A);
      idle();

      // overrun with consumer stalled
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("ov1_valid", rx_valid, 1);
      check("ov1_data",  rx_data, 8'h11);
      check("ov1_noovr", overrun, 0);
      idle();
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("ov2_pulse", overrun, 1);
      check("ov2_data",  rx_data, 8'h11);
      check("ov2_valid", rx_valid, 1);
      idle();
      check("ov2_pulse_end", overrun, 0);
      check("ov2_data_hold", rx_data, 8'h11);
      send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("ov3_noovr", overrun, 0);
      check("ov3_valid", rx_valid, 1);
      check("ov3_data",  rx_data, 8'h33);
      idle();
      check("ov3_drain", rx_valid, 0);

      // reset mid-frame
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      strobe(1'b0);
      idle();
      for (int i = 0; i < 4; i++) begin
         strobe(1'b1);
         idle();
      end
      check("mid_busy", busy, 1);
      rst = 1'b0;
      #1;
      check("mr_data",  rx_data, 0);
      check("mr_valid", rx_valid, 0);
      check("mr_perr",  parity_error, 0);
      check("mr_ferr",  framing_error, 0);
      check("mr_glitch", start_glitch, 0);
      check("mr_ovr",   overrun, 0);
      check("mr_busy",  busy, 0);
      @(negedge clk);
      rst = 1'b1;
      idle();
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("mr_next_valid", rx_valid, 1);
      check("mr_next_data",  rx_data, 8'hC3);
      check("mr_next_perr",  parity_error, 0);
      check("mr_next_ferr",  framing_error, 0);
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
